// File: rtl/hub75_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hub75_capture                                              |
// | Description : HUB75 panel-side receiver. Rebuilds each latched 64-column |
// |               line, decodes the bit plane from the OE-low exposure and   |
// |               emits one ready/valid record per column.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hub75_capture #(
  parameter int LSB_PERIOD = 15,
  parameter int MIN_EXPO   = 4
) (
  input  logic       clk_27MHz,
  input  logic       rst_n,
  input  logic       hub_clk,
  input  logic       hub_latch,
  input  logic       hub_oe,
  input  logic [4:0] hub_row,
  input  logic [2:0] hub_rgb1,
  input  logic [2:0] hub_rgb2,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [5:0] pix_x,
  output logic [4:0] pix_row,
  output logic [2:0] pix_plane,
  output logic [2:0] pix_rgb1,
  output logic [2:0] pix_rgb2,
  output logic       pix_last,
  output logic       frame_done,
  output logic       err_col,
  output logic       err_overrun
);

  typedef enum logic [1:0] {
    WAIT_LATCH = 2'd0,
    WAIT_OE    = 2'd1,
    MEASURE    = 2'd2,
    EMIT       = 2'd3
  } state_t;

  // Sync vector layout: {clk, latch, oe, row[4:0], rgb2[2:0], rgb1[2:0]}; OE idles high.
  localparam logic [13:0] c_SYNC_RST = 14'h0800;
  localparam logic [15:0] c_EXPO_MAX = 16'hFFFF;

  logic [13:0] r_sync1;
  logic [13:0] r_sync2;
  logic [2:0]  r_edge_d;
  state_t      r_state;
  logic [6:0]  r_col_cnt;
  logic [5:0]  r_shreg   [64];
  logic [5:0]  r_linebuf [64];
  logic [15:0] r_expo;
  logic [4:0]  r_row_q;
  logic        r_err_col;
  logic        r_err_overrun;
  logic        r_frame_done;
  logic        r_pix_valid;
  logic [5:0]  r_pix_x;
  logic [4:0]  r_pix_row;
  logic [2:0]  r_pix_plane;
  logic [2:0]  r_pix_rgb1;
  logic [2:0]  r_pix_rgb2;
  logic        r_pix_last;

  logic        w_clk_s;
  logic        w_latch_s;
  logic        w_oe_s;
  logic [4:0]  w_row_s;
  logic [2:0]  w_rgb2_s;
  logic [2:0]  w_rgb1_s;
  logic        w_clk_rise;
  logic        w_latch_rise;
  logic        w_oe_fall;
  logic        w_oe_rise;
  logic [5:0]  w_next_x;

  assign {w_clk_s, w_latch_s, w_oe_s, w_row_s, w_rgb2_s, w_rgb1_s} = r_sync2;
  assign w_clk_rise   = w_clk_s   & ~r_edge_d[2];
  assign w_latch_rise = w_latch_s & ~r_edge_d[1];
  assign w_oe_fall    = ~w_oe_s   &  r_edge_d[0];
  assign w_oe_rise    = w_oe_s    & ~r_edge_d[0];
  assign w_next_x     = r_pix_x + 6'd1;

  // Plane = number of thresholds (3*LSB_PERIOD<<b)>>2, b=1..7, reached by the exposure.
  function automatic logic [2:0] f_decode_plane(input logic [15:0] expo);
    logic [2:0]  cnt;
    logic [31:0] thr;
    cnt = 3'd0;
    for (int b = 1; b <= 7; b++) begin
      thr = (32'(3 * LSB_PERIOD) << b) >> 2;
      if ({16'd0, expo} >= thr) cnt = cnt + 3'd1;
    end
    return cnt;
  endfunction

  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= c_SYNC_RST;
      r_sync2  <= c_SYNC_RST;
      r_edge_d <= 3'b001;
    end else begin
      r_sync1  <= {hub_clk, hub_latch, hub_oe, hub_row, hub_rgb2, hub_rgb1};
      r_sync2  <= r_sync1;
      r_edge_d <= {w_clk_s, w_latch_s, w_oe_s};
    end
  end

  // Column capture and line hand-off run independently of the FSM state.
  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt     <= '0;
      r_err_col     <= 1'b0;
      r_err_overrun <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        r_shreg[i]   <= '0;
        r_linebuf[i] <= '0;
      end
    end else begin
      r_err_col     <= 1'b0;
      r_err_overrun <= 1'b0;
      if (w_clk_rise) begin
        r_shreg[r_col_cnt[5:0]] <= {w_rgb2_s, w_rgb1_s};
        if (r_col_cnt != 7'd127) r_col_cnt <= r_col_cnt + 7'd1;
      end
      if (w_latch_rise) begin
        r_err_col <= (r_col_cnt != 7'd64);
        r_col_cnt <= '0;
        if (r_state != EMIT) r_linebuf <= r_shreg;
        else                 r_err_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_LATCH;
      r_expo       <= '0;
      r_row_q      <= '0;
      r_frame_done <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_row    <= '0;
      r_pix_plane  <= '0;
      r_pix_rgb1   <= '0;
      r_pix_rgb2   <= '0;
      r_pix_last   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT_LATCH: begin
          if (w_latch_rise) r_state <= WAIT_OE;
        end
        WAIT_OE: begin
          if (w_oe_fall) begin
            r_state <= MEASURE;
            r_row_q <= w_row_s;
            r_expo  <= 16'd1;
          end
        end
        MEASURE: begin
          if (w_oe_rise) begin
            if (r_expo < 16'(MIN_EXPO)) begin
              r_state <= WAIT_OE;
            end else begin
              r_state     <= EMIT;
              r_pix_valid <= 1'b1;
              r_pix_x     <= 6'd0;
              r_pix_row   <= r_row_q;
              r_pix_plane <= f_decode_plane(r_expo);
              r_pix_rgb1  <= r_linebuf[0][2:0];
              r_pix_rgb2  <= r_linebuf[0][5:3];
              r_pix_last  <= 1'b0;
            end
          end else if (!w_oe_s && r_expo != c_EXPO_MAX) begin
            r_expo <= r_expo + 16'd1;
          end
        end
        EMIT: begin
          if (r_pix_valid && pix_ready) begin
            if (r_pix_x == 6'd63) begin
              r_state      <= WAIT_LATCH;
              r_pix_valid  <= 1'b0;
              r_pix_last   <= 1'b0;
              r_frame_done <= (r_pix_row == 5'd31) && (r_pix_plane == 3'd7);
            end else begin
              r_pix_x    <= w_next_x;
              r_pix_rgb1 <= r_linebuf[w_next_x][2:0];
              r_pix_rgb2 <= r_linebuf[w_next_x][5:3];
              r_pix_last <= (w_next_x == 6'd63);
            end
          end
        end
        default: r_state <= WAIT_LATCH;
      endcase
    end
  end

  assign pix_valid   = r_pix_valid;
  assign pix_x       = r_pix_x;
  assign pix_row     = r_pix_row;
  assign pix_plane   = r_pix_plane;
  assign pix_rgb1    = r_pix_rgb1;
  assign pix_rgb2    = r_pix_rgb2;
  assign pix_last    = r_pix_last;
  assign frame_done  = r_frame_done;
  assign err_col     = r_err_col;
  assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hub75_capture                                           |
// | Description : Scoreboard bench for hub75_capture.                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hub75_capture;

  logic       clk_27MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       hub_clk   = 1'b0;
  logic       hub_latch = 1'b0;
  logic       hub_oe    = 1'b1;
  logic [4:0] hub_row   = '0;
  logic [2:0] hub_rgb1  = '0;
  logic [2:0] hub_rgb2  = '0;
  logic       pix_ready = 1'b0;
  logic       pix_valid;
  logic [5:0] pix_x;
  logic [4:0] pix_row;
  logic [2:0] pix_plane;
  logic [2:0] pix_rgb1;
  logic [2:0] pix_rgb2;
  logic       pix_last;
  logic       frame_done;
  logic       err_col;
  logic       err_overrun;

  hub75_capture #(.LSB_PERIOD(15), .MIN_EXPO(4)) dut (
    .clk_27MHz  (clk_27MHz),
    .rst_n      (rst_n),
    .hub_clk    (hub_clk),
    .hub_latch  (hub_latch),
    .hub_oe     (hub_oe),
    .hub_row    (hub_row),
    .hub_rgb1   (hub_rgb1),
    .hub_rgb2   (hub_rgb2),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_row    (pix_row),
    .pix_plane  (pix_plane),
    .pix_rgb1   (pix_rgb1),
    .pix_rgb2   (pix_rgb2),
    .pix_last   (pix_last),
    .frame_done (frame_done),
    .err_col    (err_col),
    .err_overrun(err_overrun)
  );

  always #5 clk_27MHz = ~clk_27MHz;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] row;
    logic [2:0] plane;
    logic [2:0] rgb1;
    logic [2:0] rgb2;
    logic       last;
  } rec_t;

  rec_t       exp_q[$];
  int         n_total = 0;
  int         n_bad   = 0;
  int         n_err_col = 0;
  int         n_err_ovr = 0;
  int         n_frame   = 0;
  int         ready_mode = 0;  // 0 always, 1 alternate, 2 random, 3 held low
  logic [5:0] tb_sh [64];
  logic [5:0] tb_lb [64];

  initial begin
    forever begin
      @(posedge clk_27MHz);
      #1;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ~pix_ready;
        2:       pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every accepted record and checks stall stability.
  rec_t act;
  rec_t held;
  rec_t ex;
  logic held_v = 1'b0;
  always @(negedge clk_27MHz) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      act = {pix_x, pix_row, pix_plane, pix_rgb1, pix_rgb2, pix_last};
      if (held_v) begin
        n_total++;
        if (!pix_valid || act !== held) begin
          n_bad++;
          $display("FAIL stall_hold: got valid=%0d rec=%h required valid=1 rec=%h", pix_valid, act, held);
        end
      end
      if (pix_valid && pix_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_record: got x=%0d row=%0d required no record", pix_x, pix_row);
        end else begin
          ex = exp_q.pop_front();
          if (act !== ex) begin
            n_bad++;
            $display("FAIL record: got x=%0d row=%0d plane=%0d rgb1=%0d rgb2=%0d last=%0d required x=%0d row=%0d plane=%0d rgb1=%0d rgb2=%0d last=%0d",
                     act.x, act.row, act.plane, act.rgb1, act.rgb2, act.last,
                     ex.x, ex.row, ex.plane, ex.rgb1, ex.rgb2, ex.last);
          end
        end
      end
      held_v = pix_valid && !pix_ready;
      held   = act;
      if (err_col)     n_err_col++;
      if (err_overrun) n_err_ovr++;
      if (frame_done)  n_frame++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_27MHz);
      #1;
    end
  endtask

  task automatic check(input string name, input int actual, input int required);
    n_total++;
    if (actual != required) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, actual, required);
    end
  endtask

  task automatic shift_line(input int ncols, input int pat);
    for (int x = 0; x < ncols; x++) begin
      logic [5:0] xv;
      logic [2:0] r1;
      logic [2:0] r2;
      xv = 6'(x);
      case (pat)
        0:       begin r1 = xv[2:0];  r2 = ~xv[2:0];         end
        1:       begin r1 = xv[5:3];  r2 = xv[2:0] ^ 3'b101; end
        default: begin r1 = ~xv[2:0]; r2 = xv[4:2];          end
      endcase
      hub_rgb1 = r1;
      hub_rgb2 = r2;
      tb_sh[x] = {r2, r1};
      step(2);
      hub_clk = 1'b1;
      step(2);
      hub_clk = 1'b0;
    end
  endtask

  task automatic do_latch(input bit load);
    hub_latch = 1'b1;
    step(2);
    hub_latch = 1'b0;
    step(2);
    if (load) tb_lb = tb_sh;
  endtask

  task automatic push_line(input logic [4:0] row, input logic [2:0] plane);
    rec_t r;
    for (int x = 0; x < 64; x++) begin
      r.x     = 6'(x);
      r.row   = row;
      r.plane = plane;
      r.rgb1  = tb_lb[x][2:0];
      r.rgb2  = tb_lb[x][5:3];
      r.last  = (x == 63);
      exp_q.push_back(r);
    end
  endtask

  task automatic expose(input int n);
    hub_oe = 1'b0;
    step(n);
    hub_oe = 1'b1;
    step(1);
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 4000) begin
      step(1);
      b++;
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_%s: got %0d records pending required 0", name, exp_q.size());
      exp_q.delete();
    end
    step(4);
  endtask

  task automatic wait_valid(input string name);
    int b;
    b = 0;
    while (!pix_valid && b < 100) begin
      step(1);
      b++;
    end
    check(name, int'(pix_valid), 1);
  endtask

  int nexp [5] = '{21, 22, 1439, 1440, 60000};
  int pexp [5] = '{0, 1, 6, 7, 7};

  initial begin
    int ec0;
    int ov0;
    int seen;
    for (int i = 0; i < 64; i++) begin
      tb_sh[i] = '0;
      tb_lb[i] = '0;
    end
    step(3);
    check("reset_valid",  int'(pix_valid), 0);
    check("reset_fields", int'({pix_x, pix_row, pix_plane, pix_rgb1, pix_rgb2, pix_last}), 0);
    check("reset_flags",  int'({frame_done, err_col, err_overrun}), 0);
    rst_n = 1'b1;
    step(2);

    // Basic line, row 5, short exposure
    ready_mode = 0;
    ec0 = n_err_col;
    shift_line(64, 0);
    hub_row = 5'd5;
    do_latch(1);
    check("err_col_full_line", n_err_col - ec0, 0);
    push_line(5'd5, 3'd0);
    expose(16);
    drain("basic");

    // Plane decode boundaries
    for (int i = 0; i < 5; i++) begin
      shift_line(64, i % 3);
      hub_row = 5'(16 + i);
      do_latch(1);
      push_line(5'(16 + i), 3'(pexp[i]));
      expose(nexp[i]);
      drain("plane");
    end
    check("no_frame_done_yet", n_frame, 0);

    // Glitch exposure: no output, still waiting for OE
    shift_line(64, 0);
    hub_row = 5'd3;
    do_latch(1);
    expose(3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (pix_valid) seen++;
    end
    check("glitch_no_emit", seen, 0);
    push_line(5'd3, 3'd1);
    expose(30);
    drain("after_glitch");

    // Backpressure: alternating then random
    ready_mode = 1;
    shift_line(64, 2);
    hub_row = 5'd12;
    do_latch(1);
    push_line(5'd12, 3'd2);
    expose(50);
    drain("alternate");
    ready_mode = 2;
    shift_line(64, 1);
    hub_row = 5'd13;
    do_latch(1);
    push_line(5'd13, 3'd4);
    expose(200);
    drain("random");
    ready_mode = 0;

    // Short line: columns 60..63 keep the previous line
    shift_line(60, 2);
    hub_row = 5'd20;
    ec0 = n_err_col;
    do_latch(1);
    check("err_col_short", n_err_col - ec0, 1);
    push_line(5'd20, 3'd0);
    expose(16);
    drain("short");

    // Overrun while stalled in EMIT
    ready_mode = 3;
    shift_line(64, 0);
    hub_row = 5'd8;
    do_latch(1);
    push_line(5'd8, 3'd0);
    expose(16);
    wait_valid("overrun_valid_up");
    ov0 = n_err_ovr;
    ec0 = n_err_col;
    shift_line(64, 1);
    do_latch(0);
    check("err_overrun", n_err_ovr - ov0, 1);
    check("err_col_overrun_line", n_err_col - ec0, 0);
    ready_mode = 0;
    drain("overrun");

    // Frame done on row 31 plane 7
    shift_line(64, 2);
    hub_row = 5'd31;
    do_latch(1);
    push_line(5'd31, 3'd7);
    expose(1500);
    drain("frame");
    check("frame_done", n_frame, 1);

    // Reset mid-EMIT
    ready_mode = 3;
    shift_line(64, 0);
    hub_row = 5'd9;
    do_latch(1);
    expose(16);
    wait_valid("pre_reset_valid");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid",  int'(pix_valid), 0);
    check("mid_reset_fields", int'({pix_x, pix_row, pix_plane, pix_rgb1, pix_rgb2, pix_last}), 0);
    step(3);
    rst_n = 1'b1;
    ready_mode = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (pix_valid) seen++;
    end
    check("post_reset_quiet", seen, 0);
    shift_line(64, 1);
    hub_row = 5'd7;
    do_latch(1);
    push_line(5'd7, 3'd3);
    expose(100);
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
